// File: rtl/fix_serializer.sv
// fix_serializer: turns (tag, value-byte) items into a FIX byte stream "<tag>=<value><DELIM>".
// Define FIX_SERIALIZER_CHECKSUM_EN to close messages with "10=nnn<DELIM>" on TRAILER items.
module fix_serializer #(
  parameter int         TAG_W = 14,
  parameter logic [7:0] DELIM = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [7:0]       in_data,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             tag_s_o,
  output logic             tag_e_o,
  output logic             value_s_o,
  output logic             value_e_o,
  output logic             err_o
);

  localparam logic [1:0] K_TAG  = 2'b00;
  localparam logic [1:0] K_VAL  = 2'b01;
  localparam logic [1:0] K_LAST = 2'b10;
  localparam logic [1:0] K_TRL  = 2'b11;
  localparam int         CNT_W  = $clog2(TAG_W + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONV, S_TAG_DIG, S_EQ, S_VAL, S_SOH
`ifdef FIX_SERIALIZER_CHECKSUM_EN
    , S_CK_CONV, S_CK_HDR, S_CK_DIG
`endif
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [19:0]        r_bcd;
  logic [TAG_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_idx;
  logic               r_first;
  logic               r_live;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_ts, r_te, r_vs, r_ve;
  logic               r_err;

  logic               w_ld;
  logic               w_in_ready;
  logic               w_emit;
  logic [7:0]         w_byte;
  logic               w_ts, w_te, w_vs, w_ve;
  logic               w_err;
  logic               w_start_tag;
  logic               w_step;
  logic               w_shift;
  logic               w_idx_inc;
  logic               w_idx_clr;
  logic               w_first_set;
  logic [19:0]        w_adj;
`ifdef FIX_SERIALIZER_CHECKSUM_EN
  logic [7:0]         r_acc;
  logic               w_start_ck;
  logic               w_ck_clr;
  logic               w_ck_byte;
`endif

  // Double-dabble correction: bump every BCD digit >= 5 by 3 before the next shift.
  function automatic logic [19:0] bcdAdjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_adj    = bcdAdjust(r_bcd);
  assign w_ld     = !r_valid || ready_i;
  assign in_ready = w_in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_emit      = 1'b0;
    w_byte      = 8'h00;
    w_ts        = 1'b0;
    w_te        = 1'b0;
    w_vs        = 1'b0;
    w_ve        = 1'b0;
    w_err       = 1'b0;
    w_start_tag = 1'b0;
    w_step      = 1'b0;
    w_shift     = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    w_first_set = 1'b0;
`ifdef FIX_SERIALIZER_CHECKSUM_EN
    w_start_ck  = 1'b0;
    w_ck_clr    = 1'b0;
    w_ck_byte   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_in_ready = r_live;
        if (in_valid && r_live) begin
          case (in_kind)
            K_TAG: begin
              w_start_tag = 1'b1;
              w_next      = S_CONV;
            end
            K_TRL: begin
`ifdef FIX_SERIALIZER_CHECKSUM_EN
              w_start_ck = 1'b1;
              w_next     = S_CK_CONV;
`else
              w_err      = 1'b1;
`endif
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(TAG_W - 1)) w_next = S_TAG_DIG;
      end
      // Leading zero digits are skipped without waiting on the output stage.
      S_TAG_DIG: begin
        if (r_first && r_bcd[19:16] == 4'd0 && r_idx != 3'd4) begin
          w_shift   = 1'b1;
          w_idx_inc = 1'b1;
        end else if (w_ld) begin
          w_emit    = 1'b1;
          w_byte    = {4'h3, r_bcd[19:16]};
          w_ts      = r_first;
          w_te      = (r_idx == 3'd4);
          w_shift   = 1'b1;
          w_idx_inc = 1'b1;
          if (r_idx == 3'd4) w_next = S_EQ;
        end
      end
      S_EQ: begin
        if (w_ld) begin
          w_emit      = 1'b1;
          w_byte      = 8'h3D;
          w_first_set = 1'b1;
          w_next      = S_VAL;
        end
      end
      S_VAL: begin
        w_in_ready = w_ld;
        if (in_valid && w_ld) begin
          if (in_kind == K_VAL || in_kind == K_LAST) begin
            w_emit = 1'b1;
            w_byte = in_data;
            w_vs   = r_first;
            w_ve   = (in_kind == K_LAST);
            if (in_kind == K_LAST) w_next = S_SOH;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_SOH: begin
        if (w_ld) begin
          w_emit = 1'b1;
          w_byte = DELIM;
          w_next = S_IDLE;
        end
      end
`ifdef FIX_SERIALIZER_CHECKSUM_EN
      S_CK_CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(7)) w_next = S_CK_HDR;
      end
      S_CK_HDR: begin
        if (w_ld) begin
          w_emit    = 1'b1;
          w_ck_byte = 1'b1;
          w_idx_inc = 1'b1;
          case (r_idx)
            3'd0: begin w_byte = 8'h31; w_ts = 1'b1; end
            3'd1: begin w_byte = 8'h30; w_te = 1'b1; end
            default: begin
              w_byte    = 8'h3D;
              w_idx_clr = 1'b1;
              w_next    = S_CK_DIG;
            end
          endcase
        end
      end
      S_CK_DIG: begin
        if (w_ld) begin
          w_emit    = 1'b1;
          w_ck_byte = 1'b1;
          w_idx_inc = 1'b1;
          case (r_idx)
            3'd0: begin w_byte = {4'h3, r_bcd[11:8]}; w_vs = 1'b1; end
            3'd1: w_byte = {4'h3, r_bcd[7:4]};
            3'd2: begin w_byte = {4'h3, r_bcd[3:0]}; w_ve = 1'b1; end
            default: begin
              w_byte   = DELIM;
              w_ck_clr = 1'b1;
              w_next   = S_IDLE;
            end
          endcase
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live  <= 1'b0;
      r_err   <= 1'b0;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_ts    <= 1'b0;
      r_te    <= 1'b0;
      r_vs    <= 1'b0;
      r_ve    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_err  <= r_err | w_err;
      if (w_start_tag) begin
        r_bin <= in_tag;
        r_bcd <= '0;
        r_cnt <= '0;
        r_idx <= '0;
      end
`ifdef FIX_SERIALIZER_CHECKSUM_EN
      // The 8-bit sum is left-aligned so the same shifter finishes after 8 steps.
      else if (w_start_ck) begin
        r_bin <= TAG_W'(r_acc) << (TAG_W - 8);
        r_bcd <= '0;
        r_cnt <= '0;
        r_idx <= '0;
      end
`endif
      else if (w_step) begin
        {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
        r_cnt          <= r_cnt + 1'b1;
      end else begin
        if (w_shift) r_bcd <= {r_bcd[15:0], 4'h0};
        if (w_idx_clr)      r_idx <= '0;
        else if (w_idx_inc) r_idx <= r_idx + 3'd1;
      end
      if (w_start_tag || w_first_set) r_first <= 1'b1;
      else if (w_emit)                r_first <= 1'b0;
      if (w_ld) begin
        r_valid <= w_emit;
        r_data  <= w_byte;
        r_ts    <= w_ts;
        r_te    <= w_te;
        r_vs    <= w_vs;
        r_ve    <= w_ve;
      end
    end
  end

`ifdef FIX_SERIALIZER_CHECKSUM_EN
  // Summing at load time equals summing at hand-off: bytes leave in order before any trailer byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_acc <= 8'h00;
    else if (w_ck_clr)               r_acc <= 8'h00;
    else if (w_emit && !w_ck_byte)   r_acc <= r_acc + w_byte;
  end
`endif

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign tag_s_o   = r_ts;
  assign tag_e_o   = r_te;
  assign value_s_o = r_vs;
  assign value_e_o = r_ve;
  assign err_o     = r_err;

endmodule

// File: tb/tb_fix_serializer.sv
// Directed bench for fix_serializer: hand-computed byte streams and markers, backpressure hold, errors, reset.
`timescale 1ns/1ps
module tb_fix_serializer;
  localparam int TAG_W = 14;
  localparam logic [1:0] K_TAG  = 2'b00;
  localparam logic [1:0] K_VAL  = 2'b01;
  localparam logic [1:0] K_LAST = 2'b10;
  localparam logic [1:0] K_TRL  = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_kind = 2'b00;
  logic [TAG_W-1:0] in_tag = '0;
  logic [7:0]       in_data = 8'h00;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic             tag_s_o, tag_e_o, value_s_o, value_e_o, err_o;
  logic [3:0]       marks;

  int  vectorCount = 0;
  int  missCount = 0;
  int  cycleCount = 0;
  bit  bpEnable = 1'b0;
  int  popCycle[16];

  typedef struct {
    logic [7:0] data;
    logic [3:0] marks;
    int         cycle;
  } capRec_t;
  capRec_t capQ[$];

  logic        prevHold = 1'b0;
  logic [11:0] prevSnap = '0;

  fix_serializer #(.TAG_W(TAG_W), .DELIM(8'h01)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_tag(in_tag), .in_data(in_data),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .tag_s_o(tag_s_o), .tag_e_o(tag_e_o),
    .value_s_o(value_s_o), .value_e_o(value_e_o), .err_o(err_o)
  );

  assign marks = {tag_s_o, tag_e_o, value_s_o, value_e_o};

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Downstream pacing: random ready while backpressure is enabled, otherwise always ready.
  always begin
    @(posedge clk);
    #2;
    ready_i = bpEnable ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Capture every handed-off byte; a stalled byte must stay put with its markers.
  always begin
    @(posedge clk);
    #8;
    if (!rst) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) checkOutput("hold", {19'd0, valid_o, data_o, marks}, {19'd0, 1'b1, prevSnap});
      prevHold = valid_o && !ready_i;
      prevSnap = {data_o, marks};
      if (valid_o && ready_i) capQ.push_back('{data_o, marks, cycleCount});
    end
  end

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [1:0] kind, input int tag, input logic [7:0] data);
    int guard = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_kind  = kind;
    in_tag   = TAG_W'(tag);
    in_data  = data;
    while (!done && guard < 300) begin
      #6;
      done = in_ready;
      @(posedge clk);
      #2;
      guard++;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkStream(input string name, input int n, input logic [127:0] expBytes,
                             input logic [63:0] expMarks);
    int guard = 0;
    capRec_t rec;
    while (capQ.size() < n && guard < 400) begin
      @(posedge clk);
      #2;
      guard++;
    end
    repeat (3) @(posedge clk);
    #2;
    checkOutput({name, "_count"}, capQ.size(), n);
    for (int i = 0; i < n; i++) begin
      if (capQ.size() > 0) begin
        rec = capQ.pop_front();
        popCycle[i] = rec.cycle;
        checkOutput($sformatf("%s_byte%0d", name, i), {24'd0, rec.data},
                    {24'd0, expBytes[(n-1-i)*8 +: 8]});
        checkOutput($sformatf("%s_mark%0d", name, i), {28'd0, rec.marks},
                    {28'd0, expMarks[(n-1-i)*4 +: 4]});
      end else begin
        checkOutput($sformatf("%s_missing%0d", name, i), 32'd0, 32'd1);
      end
    end
    capQ.delete();
  endtask

  initial begin
    logic [47:0] fixStr;
    int guard;
    fixStr = "FIX.4.";

    #3;
    checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("rst_data", {24'd0, data_o}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("rst_marks", {28'd0, marks}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idleCycles(2);

    applyStimulus(K_TAG, 35, 8'h00);
    applyStimulus(K_LAST, 0, 8'h38);
    idleCycles(1);
    checkStream("tag35", 5, {8'h33, 8'h35, 8'h3D, 8'h38, 8'h01},
                {4'h8, 4'h4, 4'h0, 4'h3, 4'h0});

`ifdef FIX_SERIALIZER_CHECKSUM_EN
    applyStimulus(K_TRL, 0, 8'h00);
    idleCycles(1);
    checkStream("ck222", 7, {8'h31, 8'h30, 8'h3D, 8'h32, 8'h32, 8'h32, 8'h01},
                {4'h8, 4'h4, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0});
`endif

    applyStimulus(K_TAG, 8, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(K_VAL, 0, fixStr[47-8*i -: 8]);
    applyStimulus(K_LAST, 0, 8'h32);
    idleCycles(1);
    checkStream("tag8", 10,
                {8'h38, 8'h3D, 8'h46, 8'h49, 8'h58, 8'h2E, 8'h34, 8'h2E, 8'h32, 8'h01},
                {4'hC, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0});
    for (int i = 2; i < 8; i++)
      checkOutput($sformatf("b2b_%0d", i), popCycle[i+1] - popCycle[i], 32'd1);

    bpEnable = 1'b1;
    applyStimulus(K_TAG, 9, 8'h00);
    applyStimulus(K_VAL, 0, 8'h61);
    applyStimulus(K_VAL, 0, 8'h62);
    applyStimulus(K_LAST, 0, 8'h63);
    idleCycles(1);
    checkStream("tag9bp", 6, {8'h39, 8'h3D, 8'h61, 8'h62, 8'h63, 8'h01},
                {4'hC, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0});
    bpEnable = 1'b0;
    idleCycles(2);

    applyStimulus(K_VAL, 0, 8'h5A);
    idleCycles(4);
    checkOutput("perr_flag", {31'd0, err_o}, 32'd1);
    checkOutput("perr_nobyte", capQ.size(), 32'd0);
    applyStimulus(K_TAG, 0, 8'h00);
    applyStimulus(K_LAST, 0, 8'h41);
    idleCycles(1);
    checkStream("tag0", 4, {8'h30, 8'h3D, 8'h41, 8'h01}, {4'hC, 4'h0, 4'h3, 4'h0});
    checkOutput("perr_sticky", {31'd0, err_o}, 32'd1);

    applyStimulus(K_TAG, 49, 8'h00);
    in_valid = 1'b0;
    guard = 0;
    while (capQ.size() < 2 && guard < 200) begin
      @(posedge clk);
      #9;
      guard++;
    end
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err_o}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkStream("tag49", 2, {8'h34, 8'h39}, {4'h8, 4'h4});
    rst = 1'b1;
    idleCycles(2);
    checkOutput("post_rst_empty", capQ.size(), 32'd0);
    applyStimulus(K_TAG, 56, 8'h00);
    applyStimulus(K_LAST, 0, 8'h41);
    idleCycles(1);
    checkStream("tag56", 5, {8'h35, 8'h36, 8'h3D, 8'h41, 8'h01},
                {4'h8, 4'h4, 4'h0, 4'h3, 4'h0});

`ifdef FIX_SERIALIZER_CHECKSUM_EN
    applyStimulus(K_TRL, 0, 8'h00);
    idleCycles(1);
    checkStream("ck234", 7, {8'h31, 8'h30, 8'h3D, 8'h32, 8'h33, 8'h34, 8'h01},
                {4'h8, 4'h4, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0});
    checkOutput("ck_no_err", {31'd0, err_o}, 32'd0);
`else
    applyStimulus(K_TRL, 0, 8'h00);
    idleCycles(4);
    checkOutput("trl_err", {31'd0, err_o}, 32'd1);
    checkOutput("trl_nobyte", capQ.size(), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/fix_serializer.md
Name: fix_serializer

Overview:
- Transmit-side counterpart of fix_parser. Turns a stream of (tag, value-bytes) items into a serial FIX byte stream: `<tag ASCII>=<value><SOH>`.
- Optionally closes a message with a computed CheckSum field, `10=nnn<SOH>`.
- Output byte stream and tag/value markers match the fix_parser input/output conventions, so a serializer-to-parser loopback is possible.

Parameters:
- TAG_W, 14, width of binary tag input; converted to up to 5 ASCII decimal digits.
- DELIM, 8'h01, field delimiter byte emitted after every value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (rst=0 resets)
- in_valid  in  1  upstream item valid
- in_ready  out  1  item accepted when in_valid && in_ready
- in_kind  in  2  item kind: 00 TAG, 01 VALUE byte, 10 VALUE last byte, 11 TRAILER
- in_tag  in  TAG_W  binary tag number (kind TAG only)
- in_data  in  8  value byte (kinds 01/10)
- data_o  out  8  output byte
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream accepts data_o when valid_o && ready_i
- tag_s_o  out  1  data_o is first tag digit
- tag_e_o  out  1  data_o is last tag digit
- value_s_o  out  1  data_o is first value byte
- value_e_o  out  1  data_o is last value byte
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): state IDLE; data_o=0; valid_o=0; in_ready=0; all markers 0; err_o=0; checksum accumulator=0.
- Output stage is a single register. data_o and markers are held stable while valid_o && !ready_i. A new byte loads only when the register is empty or draining (!valid_o || ready_i).
- States:
  - IDLE: in_ready=1. Accepts TAG (latch in_tag, go to CONV) or TRAILER (go to CK_CONV, or drop it; see Optional Feature). A VALUE kind here sets err_o, and the item is dropped.
  - CONV: in_ready=0. Double-dabble converts in_tag to BCD, one bit per cycle, TAG_W cycles. Go to TAG_DIG.
  - TAG_DIG: emit ASCII digits (0x30+d), most significant first, leading zeros suppressed. Tag 0 emits "0". tag_s_o on the first digit, tag_e_o on the last (both on a single-digit tag). Go to EQ.
  - EQ: emit 0x3D. Go to VAL.
  - VAL: in_ready = (!valid_o || ready_i). Each accepted VALUE/VALUE-last byte passes through with one-cycle latency, giving one byte per cycle sustained.
    - value_s_o on the first byte of the field; value_e_o on the kind-10 byte.
    - Kind 10 goes to SOH.
    - TAG or TRAILER in VAL sets err_o and is dropped; state is unchanged.
  - SOH: emit DELIM. Go to IDLE.
  - CK_CONV: convert the accumulator (0..255) to 3 BCD digits, 8 cycles.
  - CK_HDR: emit "1"(tag_s_o), "0"(tag_e_o), "=".
  - CK_DIG: emit 3 digits zero-padded, value_s_o on the first, value_e_o on the third. Then emit DELIM, clear the accumulator, and go to IDLE.
- Checksum: 8-bit wrap-around sum of every byte handed off (valid_o && ready_i) since reset or the last trailer. This includes digits, '=', value bytes and DELIM. It excludes the trailer's own "10=nnn<SOH>" bytes.
- Empty value is impossible by construction: a field always carries at least one byte.
- Reset mid-field: everything returns to reset values immediately. A partial field is not completed.
- ready_i low during CONV/CK_CONV does not stall conversion, only emission.

Optional Feature:
- Macro FIX_SERIALIZER_CHECKSUM_EN.
- Defined: accumulator, CK_CONV/CK_HDR/CK_DIG states and trailer generation as above.
- Undefined: no accumulator and no checksum states. A TRAILER item in IDLE is accepted, dropped, and sets err_o.

Test Plan:
- ready_i=1; TAG 35, VALUE-last 0x38 -> bytes 33 35 3D 38 01. Markers: tag_s_o on 0x33, tag_e_o on 0x35, value_s_o and value_e_o both on 0x38.
- Checksum enabled: TAG 35/VALUE-last '8' then TRAILER -> bytes 31 30 3D 32 32 32 01 ("10=222" with SOH).
- TAG 8, VALUE bytes "FIX.4.", VALUE-last '2' -> 38 3D 46 49 58 2E 34 2E 32 01. Back-to-back value bytes show one cycle each.
- Backpressure: toggle ready_i randomly during the tag-9 field -> identical byte sequence. data_o and markers are held whenever ready_i=0.
- Protocol error: VALUE in IDLE -> err_o=1 and no output byte. A subsequent legal TAG 0/VALUE-last 'A' outputs 30 3D 41 01 with err_o still 1.
- Reset: drop rst to 0 during EQ of tag 49 -> valid_o=0 and err_o=0 the same cycle. After rst=1, TAG 56 produces a fresh 35 36 3D ..., and the checksum covers only the post-reset bytes.
